// File: rtl/play_key_graph.sv
// -----------------------------------------------------------------------------
// play_key_graph
//   Draws a row of NUM_KEYS bordered note boxes on the VGA raster and
//   highlights the currently detected note. The highlight state only moves on
//   frame_tick, so a frame never shows two different highlight states. While
//   playback runs the highlight blinks. After detection drops, the highlight
//   stays on (in a different colour) for a hold period.
//   Pixel path latency is 2 clk. The caller delays hsync/vsync by 2 to match.
//
// Ports
//   clk          pixel clock
//   reset_n      asynchronous active-low reset
//   video_on     active display area
//   pix_x/pix_y  current pixel column / row (10 bit)
//   frame_tick   one-cycle pulse at start of vertical blank
//   sel_valid    a note is currently detected
//   sel_note     detected note index (4 bit)
//   play_active  playback running, enables blinking
//   graph_rgb    registered pixel colour {r,g,b}
//   hl_on        highlight state is not IDLE (registered)
//   hl_note      latched highlighted note index (registered)
// -----------------------------------------------------------------------------
module play_key_graph #(
   parameter int NUM_KEYS     = 7,
   parameter int X0           = 32,
   parameter int Y0           = 300,
   parameter int KEY_W        = 64,
   parameter int KEY_H        = 96,
   parameter int GAP          = 8,
   parameter int BORDER       = 2,
   parameter int BLINK_FRAMES = 15,
   parameter int HOLD_FRAMES  = 30
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       video_on,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       frame_tick,
   input  logic       sel_valid,
   input  logic [3:0] sel_note,
   input  logic       play_active,
   output logic [2:0] graph_rgb,
   output logic       hl_on,
   output logic [3:0] hl_note
);

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

   // Geometry constants in 11 bits so right/bottom edges past 1023 do not wrap
   localparam logic [10:0] Y_TOP      = 11'(Y0);
   localparam logic [10:0] Y_BOT      = 11'(Y0 + KEY_H - 1);
   localparam logic [10:0] Y_IN_TOP   = 11'(Y0 + BORDER);
   localparam logic [10:0] Y_IN_BOT   = 11'(Y0 + KEY_H - 1 - BORDER);
   localparam logic [10:0] KEY_SPAN   = 11'(KEY_W - 1);
   localparam logic [10:0] BORDER_W   = 11'(BORDER);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SHOW = 2'b01,
      HOLD = 2'b10
   } hl_state_t;

   // Left x of key idx
   function automatic logic [10:0] key_left(input int idx);
      return 11'(X0 + idx * (KEY_W + GAP));
   endfunction

   // ---------------------------------------------------------------- stage 1
   logic [10:0]         x_s;
   logic [10:0]         y_s;
   logic                y_in_s;
   logic                y_edge_s;
   logic [NUM_KEYS-1:0] hit_vec_s;
   logic [NUM_KEYS-1:0] xedge_vec_s;

   logic       video_on_q, video_on_d;
   logic       key_hit_q, key_hit_d;
   logic [3:0] key_idx_q, key_idx_d;
   logic       border_hit_q, border_hit_d;

   assign x_s      = {1'b0, pix_x};
   assign y_s      = {1'b0, pix_y};
   assign y_in_s   = (y_s >= Y_TOP) && (y_s <= Y_BOT);
   assign y_edge_s = (y_s < Y_IN_TOP) || (y_s > Y_IN_BOT);

   // Key hit test: keys never overlap, so at most one bit of hit_vec_s is set
   always_comb begin
      hit_vec_s   = '0;
      xedge_vec_s = '0;
      key_idx_d   = 4'd0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         hit_vec_s[i]   = y_in_s && (x_s >= key_left(i)) &&
                          (x_s <= key_left(i) + KEY_SPAN);
         xedge_vec_s[i] = hit_vec_s[i] &&
                          ((x_s < key_left(i) + BORDER_W) ||
                           (x_s > key_left(i) + KEY_SPAN - BORDER_W));
         key_idx_d      = hit_vec_s[i] ? 4'(i) : key_idx_d;
      end
      video_on_d   = video_on;
      key_hit_d    = |hit_vec_s;
      border_hit_d = (|xedge_vec_s) || ((|hit_vec_s) && y_edge_s);
   end

   // Stage 1 pipeline register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         video_on_q   <= 1'b0;
         key_hit_q    <= 1'b0;
         key_idx_q    <= 4'd0;
         border_hit_q <= 1'b0;
      end else begin
         video_on_q   <= video_on_d;
         key_hit_q    <= key_hit_d;
         key_idx_q    <= key_idx_d;
         border_hit_q <= border_hit_d;
      end
   end

   // ------------------------------------------------------- highlight FSM
   hl_state_t       state_q, state_d;
   logic [3:0]      hl_note_q, hl_note_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            blink_phase_q, blink_phase_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            hl_on_q;
   logic            note_ok_s;
   logic [BW-1:0]   blink_step_cnt_s;
   logic            blink_step_phase_s;

   // Out-of-range notes are treated as no detection
   assign note_ok_s = sel_valid && (sel_note < 4'(NUM_KEYS));

   // One frame of blink progress; without playback the highlight is steady
   always_comb begin
      blink_step_cnt_s   = blink_cnt_q;
      blink_step_phase_s = blink_phase_q;
      if (play_active) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_step_cnt_s   = {BW{1'b0}};
            blink_step_phase_s = ~blink_phase_q;
         end else begin
            blink_step_cnt_s   = blink_cnt_q + BW'(1);
            blink_step_phase_s = blink_phase_q;
         end
      end else begin
         blink_step_cnt_s   = {BW{1'b0}};
         blink_step_phase_s = 1'b1;
      end
   end

   // Next state: only frame_tick cycles may change anything
   always_comb begin
      state_d       = state_q;
      hl_note_d     = hl_note_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      hold_cnt_d    = hold_cnt_q;
      if (frame_tick) begin
         case (state_q)
            IDLE: begin
               blink_cnt_d   = {BW{1'b0}};
               blink_phase_d = 1'b1;
               hold_cnt_d    = {HW{1'b0}};
               if (note_ok_s) begin
                  state_d   = SHOW;
                  hl_note_d = sel_note;
               end else begin
                  state_d   = IDLE;
               end
            end
            SHOW, HOLD: begin
               if (note_ok_s) begin
                  state_d = SHOW;
                  if (sel_note != hl_note_q) begin
                     hl_note_d     = sel_note;
                     blink_cnt_d   = {BW{1'b0}};
                     blink_phase_d = 1'b1;
                  end else begin
                     blink_cnt_d   = blink_step_cnt_s;
                     blink_phase_d = blink_step_phase_s;
                  end
               end else if (state_q == SHOW) begin
                  state_d       = HOLD;
                  hold_cnt_d    = {HW{1'b0}};
                  blink_cnt_d   = blink_step_cnt_s;
                  blink_phase_d = blink_step_phase_s;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  // Back to IDLE with counters at their reset values
                  state_d       = IDLE;
                  hold_cnt_d    = {HW{1'b0}};
                  blink_cnt_d   = {BW{1'b0}};
                  blink_phase_d = 1'b1;
               end else begin
                  hold_cnt_d    = hold_cnt_q + HW'(1);
                  blink_cnt_d   = blink_step_cnt_s;
                  blink_phase_d = blink_step_phase_s;
               end
            end
            default: begin
               state_d       = IDLE;
               blink_cnt_d   = {BW{1'b0}};
               blink_phase_d = 1'b1;
               hold_cnt_d    = {HW{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Highlight state registers; hl_on tracks the registered state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         hl_note_q     <= 4'd0;
         blink_cnt_q   <= {BW{1'b0}};
         blink_phase_q <= 1'b1;
         hold_cnt_q    <= {HW{1'b0}};
         hl_on_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         hl_note_q     <= hl_note_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         hold_cnt_q    <= hold_cnt_d;
         hl_on_q       <= (state_d != IDLE);
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [2:0] graph_rgb_q, graph_rgb_d;

   // Colour priority: blanking, border, highlight, plain key, background
   always_comb begin
      graph_rgb_d = 3'b110;
      if (!video_on_q) begin
         graph_rgb_d = 3'b000;
      end else if (border_hit_q) begin
         graph_rgb_d = 3'b000;
      end else if (key_hit_q && hl_on_q && (key_idx_q == hl_note_q) && blink_phase_q) begin
         graph_rgb_d = (state_q == HOLD) ? 3'b101 : 3'b100;
      end else if (key_hit_q) begin
         graph_rgb_d = 3'b111;
      end else begin
         graph_rgb_d = 3'b110;
      end
   end

   // Stage 2 output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         graph_rgb_q <= 3'b000;
      end else begin
         graph_rgb_q <= graph_rgb_d;
      end
   end

   assign graph_rgb = graph_rgb_q;
   assign hl_on     = hl_on_q;
   assign hl_note   = hl_note_q;

endmodule

// File: tb/tb_play_key_graph.sv
// -----------------------------------------------------------------------------
// tb_play_key_graph
//   Directed bench for play_key_graph with default parameters. Key i spans
//   x = 32+72*i .. 95+72*i, y = 300..395, 2-pixel border.
// -----------------------------------------------------------------------------
module tb_play_key_graph;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       video_on;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       frame_tick;
   logic       sel_valid;
   logic [3:0] sel_note;
   logic       play_active;
   logic [2:0] graph_rgb;
   logic       hl_on;
   logic [3:0] hl_note;

   int n_cmp = 0;
   int n_err = 0;

   // Fill pixels (10 px inside the left edge) of keys 0, 2, 3, 4, 5
   localparam int K0X = 42;
   localparam int K2X = 186;
   localparam int K3X = 258;
   localparam int K4X = 330;
   localparam int K5X = 402;
   localparam int KY  = 310;

   play_key_graph dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .video_on   (video_on),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .frame_tick (frame_tick),
      .sel_valid  (sel_valid),
      .sel_note   (sel_note),
      .play_active(play_active),
      .graph_rgb  (graph_rgb),
      .hl_on      (hl_on),
      .hl_note    (hl_note)
   );

   always #5 clk = ~clk;

   // Present one pixel and return the colour two clocks later
   task automatic show_pixel(input int x, input int y, input logic von,
                             output logic [2:0] rgb);
      @(negedge clk);
      pix_x    = 10'(x);
      pix_y    = 10'(y);
      video_on = von;
      @(posedge clk);
      @(posedge clk);
      #1 rgb = graph_rgb;
   endtask

   // Issue n single-cycle frame_tick pulses
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
      end
   endtask

   task automatic test_reset;
      logic [2:0] got;
      reset_n = 1'b0; video_on = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
      frame_tick = 1'b0; sel_valid = 1'b0; sel_note = 4'd0; play_active = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (graph_rgb !== 3'b000) begin n_err++; $display("FAIL rst_rgb got=%b exp=000", graph_rgb); end
      n_cmp++; if (hl_on !== 1'b0) begin n_err++; $display("FAIL rst_hl_on got=%b exp=0", hl_on); end
      n_cmp++; if (hl_note !== 4'd0) begin n_err++; $display("FAIL rst_hl_note got=%0d exp=0", hl_note); end
      @(negedge clk) reset_n = 1'b1;
      show_pixel(K0X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL key0_fill got=%b exp=111", got); end
      show_pixel(32, 300, 1'b1, got);
      n_cmp++; if (got !== 3'b000) begin n_err++; $display("FAIL key0_corner got=%b exp=000", got); end
      show_pixel(0, 0, 1'b1, got);
      n_cmp++; if (got !== 3'b110) begin n_err++; $display("FAIL background got=%b exp=110", got); end
      show_pixel(K0X, KY, 1'b0, got);
      n_cmp++; if (got !== 3'b000) begin n_err++; $display("FAIL video_off got=%b exp=000", got); end
   endtask

   task automatic test_geometry;
      logic [2:0] got;
      show_pixel(33, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b000) begin n_err++; $display("FAIL left_border got=%b exp=000", got); end
      show_pixel(34, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL first_fill got=%b exp=111", got); end
      show_pixel(94, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b000) begin n_err++; $display("FAIL right_border got=%b exp=000", got); end
      show_pixel(96, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b110) begin n_err++; $display("FAIL gap got=%b exp=110", got); end
      show_pixel(K0X, 393, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL last_fill_row got=%b exp=111", got); end
      show_pixel(K0X, 394, 1'b1, got);
      n_cmp++; if (got !== 3'b000) begin n_err++; $display("FAIL bottom_border got=%b exp=000", got); end
      show_pixel(K0X, 396, 1'b1, got);
      n_cmp++; if (got !== 3'b110) begin n_err++; $display("FAIL below_key got=%b exp=110", got); end
      show_pixel(530, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b110) begin n_err++; $display("FAIL past_last_key got=%b exp=110", got); end
   endtask

   task automatic test_steady;
      logic [2:0] got;
      sel_valid = 1'b1; sel_note = 4'd3; play_active = 1'b0;
      tick(1);
      n_cmp++; if (hl_on !== 1'b1) begin n_err++; $display("FAIL show_hl_on got=%b exp=1", hl_on); end
      n_cmp++; if (hl_note !== 4'd3) begin n_err++; $display("FAIL show_hl_note got=%0d exp=3", hl_note); end
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL show_key3 got=%b exp=100", got); end
      show_pixel(K2X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL show_key2 got=%b exp=111", got); end
      for (int f = 0; f < 4; f++) begin
         tick(10);
         show_pixel(K3X, KY, 1'b1, got);
         n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL steady_key3 frame=%0d got=%b exp=100", (f + 1) * 10, got); end
      end
   endtask

   task automatic test_blink;
      logic [2:0] got;
      play_active = 1'b1;
      tick(14);
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL blink_f14 got=%b exp=100", got); end
      tick(1);
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL blink_f15 got=%b exp=111", got); end
      tick(14);
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL blink_f29 got=%b exp=111", got); end
      tick(1);
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL blink_f30 got=%b exp=100", got); end
      tick(20);
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL blink_f50 got=%b exp=111", got); end
      sel_note = 4'd5;
      tick(1);
      show_pixel(K5X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL newnote_key5 got=%b exp=100", got); end
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL newnote_key3 got=%b exp=111", got); end
      play_active = 1'b0;
   endtask

   task automatic test_hold;
      logic [2:0] got;
      sel_valid = 1'b0;
      tick(1);
      show_pixel(K5X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b101) begin n_err++; $display("FAIL hold_key5 got=%b exp=101", got); end
      tick(29);
      n_cmp++; if (hl_on !== 1'b1) begin n_err++; $display("FAIL hold_last_on got=%b exp=1", hl_on); end
      tick(1);
      n_cmp++; if (hl_on !== 1'b0) begin n_err++; $display("FAIL hold_expired got=%b exp=0", hl_on); end
      show_pixel(K5X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL idle_key5 got=%b exp=111", got); end
      sel_valid = 1'b1;
      tick(1);
      sel_valid = 1'b0;
      tick(21);
      sel_valid = 1'b1;
      tick(1);
      n_cmp++; if (hl_on !== 1'b1) begin n_err++; $display("FAIL reassert_on got=%b exp=1", hl_on); end
      show_pixel(K5X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL reassert_key5 got=%b exp=100", got); end
   endtask

   task automatic test_invalid_and_gating;
      logic [2:0] got;
      sel_valid = 1'b0;
      tick(31);
      n_cmp++; if (hl_on !== 1'b0) begin n_err++; $display("FAIL back_idle got=%b exp=0", hl_on); end
      sel_valid = 1'b1; sel_note = 4'd9;
      tick(1);
      n_cmp++; if (hl_on !== 1'b0) begin n_err++; $display("FAIL note9_idle got=%b exp=0", hl_on); end
      sel_note = 4'd2;
      repeat (10) @(posedge clk);
      show_pixel(K2X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL no_tick_key2 got=%b exp=111", got); end
      n_cmp++; if (hl_on !== 1'b0) begin n_err++; $display("FAIL no_tick_on got=%b exp=0", hl_on); end
      tick(1);
      n_cmp++; if (hl_note !== 4'd2) begin n_err++; $display("FAIL tick_note2 got=%0d exp=2", hl_note); end
      sel_note = 4'd4;
      show_pixel(K4X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL gated_key4 got=%b exp=111", got); end
      show_pixel(K2X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL gated_key2 got=%b exp=100", got); end
      n_cmp++; if (hl_note !== 4'd2) begin n_err++; $display("FAIL gated_note got=%0d exp=2", hl_note); end
   endtask

   task automatic test_reset_mid;
      logic [2:0] got;
      sel_note = 4'd3;
      tick(1);
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL pre_reset_key3 got=%b exp=100", got); end
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (graph_rgb !== 3'b000) begin n_err++; $display("FAIL midrst_rgb got=%b exp=000", graph_rgb); end
      n_cmp++; if (hl_on !== 1'b0) begin n_err++; $display("FAIL midrst_on got=%b exp=0", hl_on); end
      n_cmp++; if (hl_note !== 4'd0) begin n_err++; $display("FAIL midrst_note got=%0d exp=0", hl_note); end
      @(negedge clk) reset_n = 1'b1;
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b111) begin n_err++; $display("FAIL post_reset_key3 got=%b exp=111", got); end
      tick(1);
      show_pixel(K3X, KY, 1'b1, got);
      n_cmp++; if (got !== 3'b100) begin n_err++; $display("FAIL post_tick_key3 got=%b exp=100", got); end
   endtask

   initial begin
      test_reset;
      test_geometry;
      test_steady;
      test_blink;
      test_hold;
      test_invalid_and_gating;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
